md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Multiply/divide unit for the Execute stage of the P6 pipeline; owns HI/LO.
//   - Accepts a one-cycle start pulse plus op code from Execute.
//   - Holds busy for a fixed latency, then commits results to HI/LO.
//   - The hazard unit uses start|busy to stall any MD-class instruction in Decode.
// PARAMETERS
//   MUL_LAT  5   cycles busy for mult/multu (and madd/msub); must be >=1
//   DIV_LAT  10  cycles busy for div/divu; must be >=1
// PORTS
//   clk     in   1   system clock, all state on rising edge
//   reset   in   1   synchronous, active-high reset
//   start   in   1   one-cycle request; op and operands sampled on this edge
//   md_op   in   4   operation code (`MD_* in macros.v)
//   a       in   32  rs operand (forwarded value from Execute)
//   b       in   32  rt operand (forwarded value from Execute)
//   busy    out  1   registered; high while an operation is in flight
//   hi      out  32  committed HI register (mfhi reads this directly)
//   lo      out  32  committed LO register (mflo reads this directly)
// BEHAVIOUR
//   - Reset: busy=0, hi=0, lo=0, counter=0, pending result discarded.
//     Reset takes priority over every other event, including an in-flight op.
//   - Ops: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
//   - FSM, IDLE/RUN:
//     - IDLE + start + mult/div class: capture the computed {hi,lo} into the
//       pending regs and load counter=LAT; busy=1 from the next cycle. -> RUN
//     - RUN: counter decrements each cycle. When counter==1, commit pending
//       -> hi/lo on that edge and set busy=0. -> IDLE
//     - Net timing: busy is high for exactly LAT cycles. The new hi/lo are
//       visible in the first cycle with busy=0.
//   - MTHI/MTLO with start in IDLE: write a into hi (or lo) on that edge; busy
//     stays 0. Zero latency.
//   - start while busy=1, or MD_NONE/undefined op with start: ignored. No state
//     change; the in-flight op continues untouched.
//   - Arithmetic:
//     - MULT: signed 32x32 -> 64 ({hi,lo}). MULTU: unsigned.
//     - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//     - DIVU: unsigned quotient/remainder.
//     - Divide by zero: busy still runs DIV_LAT cycles; hi/lo keep prior values.
//     - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   - Operands are sampled only on the start edge; later changes on a/b are ignored.
//   - hi/lo change only at reset, at commit, or on an MTHI/MTLO edge.
// CONFIGURATION
//   Macro MDU_MADD_EN:
//   - Defined: adds MADD=7, MADDU=8, MSUB=9, MSUBU=10. {hi,lo} +/- (a*b),
//     signed/unsigned per op, wraps mod 2^64, MUL_LAT latency. The accumulate
//     base is the hi/lo committed at the start edge.
//   - Undefined: codes 7-10 are treated as undefined ops (ignored); no
//     accumulator adder is synthesised.
// STRUCTURE
//   - macros.v (shared header): `MD_* op codes and the `md_op field width.
//     Execute's decoder also uses these codes.
//   - Sub-module md_calc (combinational): md_op, a, b, hi, lo -> 64-bit result
//     and result-valid flag (0 for div-by-zero). Also holds the MADD paths.
//   - md_unit keeps the FSM, counter, pending regs and HI/LO.
// TESTING
//   - Reset then idle -> busy=0, hi=0, lo=0; reset during RUN at counter=3 ->
//     next cycle busy=0, hi=lo=0, no later commit.
//   - MULT a=0xFFFFFFFE(-2) b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF,
//     lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//   - DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/0 -> busy 10 cycles; hi/lo unchanged.
//   - MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never asserts.
//     Then MTLO 0xCAFEBABE -> lo updated.
//   - MULT started, then start+DIVU issued while busy -> second request ignored;
//     only the MULT result commits after 5 cycles.
//   - With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1 b=1 -> hi=1, lo=0 after
//     5 cycles. Without it: same stimulus -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// op-class helpers used by both md_unit and its datapath md_unit_calc.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU op codes).
package md_unit_pkg;

    localparam int MD_OP_W = 4;

    // Op codes shared with the Execute-stage decoder.
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that take MUL_LAT cycles. The accumulate ops only exist when the
    // feature is built in; otherwise their codes fall through as undefined.
    function automatic logic is_mul_class(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_class(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational MD datapath: 64-bit {hi,lo} result for the op on a/b.
// Ports: md_op_i, a_i, b_i, hi_i, lo_i (accumulate base) -> res_o, res_vld_o.
// res_vld_o is 0 only for a divide by zero. Macro MDU_MADD_EN adds the MADD/MSUB paths.
module md_unit_calc
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op_i,
    input  logic [31:0]        a_i,
    input  logic [31:0]        b_i,
    input  logic [31:0]        hi_i,
    input  logic [31:0]        lo_i,
    output logic [63:0]        res_o,
    output logic               res_vld_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_signed;
    logic        [31:0] dvd_mag;
    logic        [31:0] dvs_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quo;
    logic        [31:0] rem;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};

    // One unsigned divider serves both DIV and DIVU. Signed division works on
    // magnitudes and fixes the signs afterwards, which also yields the
    // 0x80000000 / -1 -> 0x80000000 rem 0 result without a special case.
    // A zero divisor is replaced by 1 so the divider never sees it.
    assign div_signed = (md_op_i == MD_DIV);
    assign dvd_mag    = (div_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign dvs_mag    = (b_i == 32'd0) ? 32'd1 :
                        ((div_signed && b_i[31]) ? (32'd0 - b_i) : b_i);
    assign q_mag      = dvd_mag / dvs_mag;
    assign r_mag      = dvd_mag % dvs_mag;
    assign quo        = (div_signed && (a_i[31] ^ b_i[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem        = (div_signed && a_i[31]) ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_i, lo_i};
`else
    logic unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
`endif

    always_comb begin
        res_o     = 64'd0;
        res_vld_o = 1'b1;
        case (md_op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV, MD_DIVU: begin
                res_o     = {rem, quo};
                res_vld_o = (b_i != 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  res_o = acc + prod_s;
            MD_MADDU: res_o = acc + prod_u;
            MD_MSUB:  res_o = acc - prod_s;
            MD_MSUBU: res_o = acc - prod_u;
`endif
            default:  res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for Execute; owns HI/LO. Ports: clk, reset (sync, high),
// start/md_op/a/b request, busy (registered), hi/lo (committed registers).
// Latency MUL_LAT / DIV_LAT busy cycles; MTHI/MTLO zero latency. Macro: MDU_MADD_EN.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        pend_q;
    logic               pend_vld_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic [63:0]        calc_res;
    logic               calc_vld;

    // Accumulate base is the committed HI/LO at the start edge.
    md_unit_calc u_md_calc (
        .md_op_i   (md_op),
        .a_i       (a),
        .b_i       (b),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .res_o     (calc_res),
        .res_vld_o (calc_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // The result is computed now from the start-edge
                        // operands; the counter only delays its commit.
                        if (is_mul_class(md_op) || is_div_class(md_op)) begin
                            pend_q     <= calc_res;
                            pend_vld_q <= calc_vld;
                            cnt_q      <= is_div_class(md_op) ? CNT_W'(DIV_LAT)
                                                              : CNT_W'(MUL_LAT);
                            busy_q     <= 1'b1;
                            state_q    <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored here: the hazard unit stalls on busy.
                    if (cnt_q == CNT_W'(1)) begin
                        if (pend_vld_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
